// File: rtl/multicycle_alu.sv
// Multi-cycle integer ALU: single-cycle base ops plus iterative RISC-V M-extension
// multiply/divide (one bit per cycle), with valid/ready handshakes on both sides.
module multicycle_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] sr1,
    input  logic [XLEN-1:0] sr2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned AW  = 2 * XLEN;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state, state_nxt;
    logic [SHW-1:0]  cnt, cnt_nxt;
    logic [AW-1:0]   acc, acc_nxt;
    logic [XLEN-1:0] opnd, opnd_nxt;
    logic            neg, neg_nxt;
    logic [2:0]      mfn, mfn_nxt;
    logic [XLEN-1:0] out_nxt;
    logic            out_valid_nxt;

    // Single-cycle base operations
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] base_res;

    always_comb begin
        sh       = sr2[SHW-1:0];
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = sr1 + sr2;
            4'b0001: base_res = sr1 - sr2;
            4'b0010: base_res = sr1 << sh;
            4'b0100: base_res = {{(XLEN-1){1'b0}}, $signed(sr1) < $signed(sr2)};
            4'b0110: base_res = {{(XLEN-1){1'b0}}, sr1 < sr2};
            4'b1000: base_res = sr1 ^ sr2;
            4'b1010: base_res = sr1 >> sh;
            4'b1011: base_res = XLEN'($signed(sr1) >>> sh);
            4'b1100: base_res = sr1 | sr2;
            4'b1110: base_res = sr1 & sr2;
            4'b1101: base_res = sr1;
            4'b1111: base_res = sr2;
            default: base_res = '0;
        endcase
    end

    // Operand magnitudes and result sign for M ops
    logic            m_div, s1, s2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;

    always_comb begin
        m_div    = op[2];
        s1       = m_div ? ~op[0] : (op[1] ^ op[0]);
        s2       = m_div ? ~op[0] : (op[1:0] == 2'b01);
        neg1     = s1 & sr1[XLEN-1];
        neg2     = s2 & sr2[XLEN-1];
        mag1     = neg1 ? -sr1 : sr1;
        mag2     = neg2 ? -sr2 : sr2;
        div_zero = (sr2 == '0);
        div_ovf  = ~op[0] & (sr1 == MIN_NEG) & (sr2 == '1);
    end

    // One shift-add or restoring-divide step, plus final sign fix
    logic [XLEN:0]   mul_sum, div_rsh, div_diff;
    logic [AW-1:0]   acc_it, prod_fix;
    logic [XLEN-1:0] div_val, div_fix, calc_res;

    always_comb begin
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_rsh  = acc[AW-1:XLEN-1];
        div_diff = div_rsh - {1'b0, opnd};
        if (mfn[2]) begin
            acc_it = {(div_diff[XLEN] ? div_rsh[XLEN-1:0] : div_diff[XLEN-1:0]),
                      acc[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            acc_it = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg ? -acc_it : acc_it;
        div_val  = mfn[1] ? acc_it[AW-1:XLEN] : acc_it[XLEN-1:0];
        div_fix  = neg ? -div_val : div_val;
        if (mfn[2]) begin
            calc_res = div_fix;
        end else if (mfn[1:0] == 2'b00) begin
            calc_res = prod_fix[XLEN-1:0];
        end else begin
            calc_res = prod_fix[AW-1:XLEN];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        acc_nxt       = acc;
        opnd_nxt      = opnd;
        neg_nxt       = neg;
        mfn_nxt       = mfn;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!op[4]) begin
                        out_nxt       = base_res;
                        out_valid_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else if (m_div && div_zero) begin
                        out_nxt       = op[1] ? sr1 : '1;
                        out_valid_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else if (m_div && div_ovf) begin
                        out_nxt       = op[1] ? '0 : MIN_NEG;
                        out_valid_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        cnt_nxt   = '0;
                        mfn_nxt   = op[2:0];
                        acc_nxt   = {{XLEN{1'b0}}, (m_div ? mag1 : mag2)};
                        opnd_nxt  = m_div ? mag2 : mag1;
                        neg_nxt   = (m_div && op[1]) ? neg1 : (neg1 ^ neg2);
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                acc_nxt = acc_it;
                cnt_nxt = cnt + SHW'(1);
                if (cnt == SHW'(XLEN - 1)) begin
                    out_nxt       = calc_res;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg       <= 1'b0;
            mfn       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            opnd      <= opnd_nxt;
            neg       <= neg_nxt;
            mfn       <= mfn_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against a plain-arithmetic model.
module tb_multicycle_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] sr1;
    logic [31:0] sr2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    multicycle_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sr1       (sr1),
        .sr2       (sr2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] pu;
        longint      ps;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        if (!o[4]) begin
            case (o[3:0])
                4'b0000: return a + b;
                4'b0001: return a - b;
                4'b0010: return a << b[4:0];
                4'b0100: return (sa < sb) ? 32'd1 : 32'd0;
                4'b0110: return (a < b) ? 32'd1 : 32'd0;
                4'b1000: return a ^ b;
                4'b1010: return a >> b[4:0];
                4'b1011: return 32'(sa >>> b[4:0]);
                4'b1100: return a | b;
                4'b1110: return a & b;
                4'b1101: return a;
                4'b1111: return b;
                default: return 32'd0;
            endcase
        end
        case (o[2:0])
            3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
            3'd2: begin ps = longint'(sa) * longint'({32'd0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[4]) return 1;
        if (o[2] && b == 32'd0) return 1;
        if (o[2] && !o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request, check result and latency, optionally stall the consumer
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input bit inject);
        logic [31:0] exp;
        int          lat;
        exp = ref_alu(o, a, b);
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        op = o; sr1 = a; sr2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(ref_lat(o, a, b)));
        check({tag, ".out"}, 64'(out), 64'(exp));
        if (inject) begin
            in_valid = 1'b1; op = 5'b00000; sr1 = 32'd1; sr2 = 32'd1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_out"}, 64'(out), 64'(exp));
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_busy"}, 64'(busy), 64'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ret_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".ret_rdy"}, 64'(in_ready), 64'd1);
        if (inject) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, ".dropped"}, 64'(out_valid), 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_NEG;
            3: return 32'($urandom_range(0, 9));
            4: return -32'($urandom_range(1, 9));
            5: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] ro;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        sr1       = '0;
        sr2       = '0;
        #2;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.out", 64'(out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Idle out_ready has no effect
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ordy.valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        run_op("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);
        run_op("mulhu",   5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("mulh",    5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_ovf", 5'b10100, MIN_NEG, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("rem_ovf", 5'b10110, MIN_NEG, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("divu_z",  5'b10101, 32'd7, 32'd0, 0, 1'b0);
        run_op("remu_z",  5'b10111, 32'd7, 32'd0, 0, 1'b0);
        run_op("div_neg", 5'b10100, -32'd7, 32'd2, 0, 1'b0);
        run_op("rem_neg", 5'b10110, -32'd7, 32'd2, 0, 1'b0);
        run_op("mulhsu",  5'b11010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("bp",      5'b10000, 32'd12345, 32'd678, 10, 1'b1);

        // Reset in the middle of a DIVU
        @(negedge clk);
        op = 5'b10101; sr1 = 32'd1000; sr2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("midrst.busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.valid", 64'(out_valid), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.no_result", 64'(out_valid), 64'd0);
        run_op("post_rst_add", 5'b00000, 32'd2, 32'd3, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                ro = {1'b0, 4'($urandom_range(0, 15))};
            end else begin
                ro = {1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
            end
            run_op("rand", ro, rand_operand(), rand_operand(), $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
